// File: rtl/mem_write_buffer.sv
// Posted write buffer between the data cache and slow memory; reads wait for older writes to drain.
// Optional macro WB_FORWARD_EN: reads that hit a buffered address are answered from the buffer.
module mem_write_buffer #(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         proc_reset,
   input  logic         c_read,
   input  logic         c_write,
   input  logic [27:0]  c_addr,
   input  logic [127:0] c_wdata,
   output logic [127:0] c_rdata,
   output logic         c_ready,
   output logic         mem_read,
   output logic         mem_write,
   output logic [27:0]  mem_addr,
   output logic [127:0] mem_wdata,
   input  logic [127:0] mem_rdata,
   input  logic         mem_ready
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic {D_IDLE, D_BUSY} drainState_t;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_MEM, R_RESP} readState_t;

   logic [27:0]   addrMem_q [DEPTH];
   logic [127:0]  dataMem_q [DEPTH];
   logic [PW-1:0] wrPtr_q, rdPtr_q;
   logic [CW-1:0] count_q, count_d;

   drainState_t   dState_q;
   readState_t    rState_q;
   logic [27:0]   rdAddr_q;
   logic          c_ready_q, mem_read_q, mem_write_q;
   logic [127:0]  c_rdata_q, mem_wdata_q;
   logic [27:0]   mem_addr_q;

   logic full, empty, reqIdle, wrAccept, rdAccept, pop;
   logic          fwdHit;
   logic [127:0]  fwdData;

   // A request is only considered when no completion pulse is out, so a held request is taken once.
   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);
   assign reqIdle  = !c_ready_q && (rState_q == R_IDLE);
   assign wrAccept = reqIdle && c_write && !full;
   assign rdAccept = reqIdle && c_read && !c_write;
   assign pop      = (dState_q == D_BUSY) && mem_ready;

   always_comb begin
      count_d = count_q;
      case ({wrAccept, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

`ifdef WB_FORWARD_EN
   logic [PW-1:0] fwdIdx;

   // Scan oldest to youngest so the last match, the youngest write, wins.
   always_comb begin
      fwdHit  = 1'b0;
      fwdData = '0;
      fwdIdx  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         fwdIdx = rdPtr_q + PW'(i);
         if ((CW'(i) < count_q) && (addrMem_q[fwdIdx] == c_addr)) begin
            fwdHit  = 1'b1;
            fwdData = dataMem_q[fwdIdx];
         end
      end
   end
`else
   assign fwdHit  = 1'b0;
   assign fwdData = '0;
`endif

   always_ff @(posedge clk) begin
      if (proc_reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (wrAccept) wrPtr_q <= wrPtr_q + PW'(1);
         if (pop)      rdPtr_q <= rdPtr_q + PW'(1);
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wrAccept) begin
         addrMem_q[wrPtr_q] <= c_addr;
         dataMem_q[wrPtr_q] <= c_wdata;
      end
   end

   // Drain and read FSMs share the memory address register; their memory phases never overlap
   // because a read only leaves R_WAIT once the buffer is empty and the drain side is idle.
   always_ff @(posedge clk) begin
      if (proc_reset) begin
         dState_q    <= D_IDLE;
         rState_q    <= R_IDLE;
         rdAddr_q    <= '0;
         c_ready_q   <= 1'b0;
         c_rdata_q   <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         c_ready_q <= wrAccept;

         case (dState_q)
            D_IDLE: begin
               if (!empty && (rState_q != R_MEM)) begin
                  mem_write_q <= 1'b1;
                  mem_addr_q  <= addrMem_q[rdPtr_q];
                  mem_wdata_q <= dataMem_q[rdPtr_q];
                  dState_q    <= D_BUSY;
               end
            end
            D_BUSY: begin
               if (mem_ready) begin
                  mem_write_q <= 1'b0;
                  dState_q    <= D_IDLE;
               end
            end
            default: dState_q <= D_IDLE;
         endcase

         case (rState_q)
            R_IDLE: begin
               if (rdAccept) begin
                  rdAddr_q <= c_addr;
                  if (fwdHit) begin
                     c_rdata_q <= fwdData;
                     c_ready_q <= 1'b1;
                     rState_q  <= R_RESP;
                  end else begin
                     rState_q  <= R_WAIT;
                  end
               end
            end
            R_WAIT: begin
               if (empty && (dState_q == D_IDLE)) begin
                  mem_read_q <= 1'b1;
                  mem_addr_q <= rdAddr_q;
                  rState_q   <= R_MEM;
               end
            end
            R_MEM: begin
               if (mem_ready) begin
                  mem_read_q <= 1'b0;
                  c_rdata_q  <= mem_rdata;
                  c_ready_q  <= 1'b1;
                  rState_q   <= R_RESP;
               end
            end
            R_RESP: rState_q <= R_IDLE;
            default: rState_q <= R_IDLE;
         endcase
      end
   end

   assign c_ready   = c_ready_q;
   assign c_rdata   = c_rdata_q;
   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule
